// File: rtl/lsu_if.sv
// DTCM request/grant/response bus between the load/store unit (master) and the
// tightly-coupled data memory (slave).
interface lsu_if #(
    parameter int ADDR_W = 32
);
    logic              dtcm_req;
    logic              dtcm_we;
    logic [3:0]        dtcm_be;
    logic [ADDR_W-1:0] dtcm_addr;
    logic [31:0]       dtcm_wdata;
    logic              dtcm_gnt;
    logic              dtcm_rvalid;
    logic [31:0]       dtcm_rdata;

    modport master (
        output dtcm_req, dtcm_we, dtcm_be, dtcm_addr, dtcm_wdata,
        input  dtcm_gnt, dtcm_rvalid, dtcm_rdata
    );

    modport slave (
        input  dtcm_req, dtcm_we, dtcm_be, dtcm_addr, dtcm_wdata,
        output dtcm_gnt, dtcm_rvalid, dtcm_rdata
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one DTCM transaction per load/store, pipeline stalled until done.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are trapped instead of issued.
module lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_mem_read,
    input  logic              ctrl_mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [4:0]        rd_idx,
    output logic              lsu_busy,
    output logic              lsu_rvalid,
    output logic [31:0]       lsu_rdata,
    output logic [4:0]        lsu_rd_idx,
    output logic              lsu_misalign,
    lsu_if.master             dtcm
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t     state;
    size_t      size_p0;
    logic       access_p0;
    logic       trap_p0;
    size_t      size_p1;
    logic       uns_p1;
    logic [1:0] off_p1;
    logic [4:0] rd_p1;

    // Reserved encodings (x11, 110) fall through to word accesses.
    function automatic size_t size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input size_t sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input size_t sz, input logic [31:0] d);
        case (sz)
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input size_t sz, input logic uns,
                                             input logic [1:0] off, input logic [31:0] d);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = 32'h0;
        b  = 8'sh0;
        h  = 16'sh0;
        case (sz)
            SZ_B: begin
                sh = d >> {off, 3'b000};
                b  = sh[7:0];
                return uns ? {24'h0, b} : {{24{b[7]}}, b};
            end
            SZ_H: begin
                sh = d >> {off[1], 4'b0000};
                h  = sh[15:0];
                return uns ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: return d;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
        return (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'b00);
    endfunction

    assign trap_p0 = is_misaligned(size_p0, addr[1:0]);
`else
    assign trap_p0      = 1'b0;
    assign lsu_misalign = 1'b0;
`endif

    assign size_p0   = size_of(funct3);
    assign access_p0 = ctrl_mem_read | ctrl_mem_write;
    assign lsu_busy  = (state != IDLE) | ((state == IDLE) & access_p0 & ~trap_p0);

    // Accept stage: bus fields and load-return fields are captured together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            dtcm.dtcm_req   <= 1'b0;
            dtcm.dtcm_we    <= 1'b0;
            dtcm.dtcm_be    <= 4'h0;
            dtcm.dtcm_addr  <= '0;
            dtcm.dtcm_wdata <= 32'h0;
            lsu_rvalid      <= 1'b0;
            lsu_rdata       <= 32'h0;
            lsu_rd_idx      <= 5'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            lsu_misalign    <= 1'b0;
`endif
        end else begin
            lsu_rvalid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            lsu_misalign <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (access_p0) begin
                        if (trap_p0) begin
`ifdef LSU_MISALIGN_TRAP_EN
                            lsu_misalign <= 1'b1;
`endif
                        end else begin
                            state           <= REQ;
                            dtcm.dtcm_req   <= 1'b1;
                            dtcm.dtcm_we    <= ctrl_mem_write;
                            dtcm.dtcm_be    <= byte_en(size_p0, addr[1:0]);
                            dtcm.dtcm_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            dtcm.dtcm_wdata <= store_lanes(size_p0, wdata);
                        end
                    end
                end
                REQ: begin
                    if (dtcm.dtcm_gnt) begin
                        dtcm.dtcm_req <= 1'b0;
                        state         <= dtcm.dtcm_we ? IDLE : WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (dtcm.dtcm_rvalid) begin
                        lsu_rvalid <= 1'b1;
                        lsu_rdata  <= load_ext(size_p1, uns_p1, off_p1, dtcm.dtcm_rdata);
                        lsu_rd_idx <= rd_p1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && access_p0 && !trap_p0) begin
            size_p1 <= size_p0;
            uns_p1  <= funct3[2];
            off_p1  <= addr[1:0];
            rd_p1   <= rd_idx;
        end
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the execute stage and the DTCM port. It consumes the `ctrl_mem_read`/`ctrl_mem_write` qualifiers produced by the decoder together with funct3, the ALU address and rs2 data. It runs a request/grant/response transaction on the DTCM bus and stalls the pipeline until the access completes. For loads it returns a sign- or zero-extended result plus the destination register index for writeback.

## Interface
- `ADDR_W`, 32, byte address width on both the core side and the DTCM side.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ctrl_mem_read`  in  1  load request from the decoder.
- `ctrl_mem_write`  in  1  store request from the decoder.
- `funct3`  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  ADDR_W  byte address (ALU result).
- `wdata`  in  32  store data (rs2).
- `rd_idx`  in  5  load destination register.
- `lsu_busy`  out  1  stall; combinational.
- `lsu_rvalid`  out  1  one-cycle load-writeback strobe.
- `lsu_rdata`  out  32  extended load result.
- `lsu_rd_idx`  out  5  destination register index for `lsu_rdata`.
- `lsu_misalign`  out  1  one-cycle misaligned-access strobe.
- `dtcm_req`  out  1  bus request.
- `dtcm_we`  out  1  1 = write.
- `dtcm_be`  out  4  byte enables.
- `dtcm_addr`  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- `dtcm_wdata`  out  32  lane-replicated store data.
- `dtcm_gnt`  in  1  request accepted.
- `dtcm_rvalid`  in  1  read data valid.
- `dtcm_rdata`  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT_R. Reset state is IDLE.
- All registered outputs reset to 0.
- IDLE: when read or write is asserted, latch the access fields and go to REQ.
  - If both read and write are asserted, the write wins.
  - Illegal funct3 values (011/110/111) are treated as word accesses.
- Byte enables:
  - B: `4'b0001 << addr[1:0]`.
  - H: `4'b0011 << {addr[1],1'b0}`.
  - W: `4'b1111`.
- Store data: B replicates `wdata[7:0]` into all 4 lanes; H replicates `wdata[15:0]` into both halves; W passes through.
- REQ: `dtcm_req`=1 with address, enables and data held stable until `dtcm_gnt`.
  - Write granted: go to IDLE.
  - Read granted: go to WAIT_R.
- WAIT_R: on `dtcm_rdata` with `dtcm_rvalid`:
  - Shift the data right by `8*addr[1:0]` (H uses `addr[1]` only).
  - Extend per funct3 (bit 2 = 1 means zero-extend).
  - Register the result into `lsu_rdata`/`lsu_rd_idx` and pulse `lsu_rvalid`. Go to IDLE.
- `dtcm_rvalid` outside WAIT_R is ignored.
- `lsu_busy` = (state != IDLE) | (IDLE & (read|write) & !misaligned-trap).
- `lsu_rdata`/`lsu_rd_idx` hold their last value between strobes.
- Reset asserted mid-transaction: immediately return to IDLE with `dtcm_req`=0. Any outstanding response is discarded; the DTCM shares `rst_n`.

## Timing
- Accept at cycle 0; `dtcm_req` is high from cycle 1.
- Zero-wait store: `dtcm_gnt` in cycle 1, so `lsu_busy` is high for cycles 0–1 and low in cycle 2.
- Zero-wait load: `dtcm_gnt` in cycle 1, `dtcm_rvalid` in cycle 2, `lsu_rvalid` in cycle 3. `lsu_busy` is high for cycles 0–2 and low in cycle 3, which is when writeback happens.
- Each gnt wait state adds one cycle. Each rvalid wait state adds one cycle.
- A new access may be accepted in the same cycle `lsu_rvalid` is high.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned means H with `addr[0]`=1, or W with `addr[1:0]`!=0.
  - A misaligned access issues no bus transaction and `lsu_busy` stays 0.
  - `lsu_misalign` pulses 1 in the cycle after the access is presented.
- Not defined:
  - Address bits that do not select a lane are ignored (H ignores bit 0, W ignores bits 1:0).
  - The access proceeds normally and `lsu_misalign` is tied 0.

## Test plan
- sw: addr 0x104, wdata 0xDEADBEEF, gnt immediately -> `dtcm_addr` 0x104, `be` 4'hF, `we`=1; `lsu_busy` low 2 cycles after accept.
- sb: addr 0x203, wdata 0x000000A5 -> `be` 4'b1000, `dtcm_wdata` 0xA5A5A5A5.
- lb: addr 0x102, rdata 0x12F63456, rd_idx 7 -> `lsu_rdata` 0xFFFFFFF6, `lsu_rd_idx` 7.
- lhu: addr 0x102, same rdata -> `lsu_rdata` 0x000012F6.
- lw with gnt delayed 3 cycles and rvalid delayed 2 -> `dtcm_req` and address stable for 4 cycles; `lsu_rvalid` at cycle 8; exactly one strobe.
- lw at addr 0x101:
  - Macro on: no `dtcm_req` and `lsu_misalign`=1 for one cycle.
  - Macro off: `dtcm_addr` 0x100, `be` 4'hF.
- `rst_n` dropped in WAIT_R -> `dtcm_req`=0 and `lsu_busy`=0 immediately; a late `dtcm_rvalid` after release produces no `lsu_rvalid`.
